// File: rtl/rl_pkg.sv
// Shared definitions for the Q-learning datapath: widths, action codes,
// the action selector FSM states and grid row/column helpers.
package rl_pkg;

    localparam int STATE_W = 6;
    localparam int ACT_W   = 4;
    localparam int Q_W     = 16;

    localparam logic [ACT_W-1:0] ACT_UP    = 4'b0000;
    localparam logic [ACT_W-1:0] ACT_DOWN  = 4'b0001;
    localparam logic [ACT_W-1:0] ACT_LEFT  = 4'b0010;
    localparam logic [ACT_W-1:0] ACT_RIGHT = 4'b0011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECIDE,
        S_EXPLORE,
        S_READ0,
        S_READ1,
        S_READ2,
        S_READ3,
        S_LAST,
        S_DONE
    } sel_state_t;

    function automatic logic [2:0] state_row(input logic [STATE_W-1:0] s);
        return s[5:3];
    endfunction

    function automatic logic [2:0] state_col(input logic [STATE_W-1:0] s);
        return s[2:0];
    endfunction

    // True when taking action a from cell s stays on the 8x8 grid.
    function automatic logic act_legal(input logic [STATE_W-1:0] s, input logic [1:0] a);
        case (a)
            2'd0:    return state_row(s) != 3'd0;
            2'd1:    return state_row(s) != 3'd7;
            2'd2:    return state_col(s) != 3'd0;
            default: return state_col(s) != 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/action_selector_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts every cycle.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    // Shift left, feeding back the XOR of the tap bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector. On start it snapshots the state and the
// LFSR, then either picks a random action or scans the four Q-values of the
// state and returns the signed argmax (ties to the lowest index).
// Optional define ACTION_MASK_EN excludes actions that would leave the grid.
module action_selector
    import rl_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [STATE_W-1:0]    current_state,
    input  logic [7:0]            epsilon,
    output logic                  q_rd_en,
    output logic [STATE_W+1:0]    q_addr,
    input  logic signed [Q_W-1:0] q_rdata,
    output logic [ACT_W-1:0]      action,
    output logic                  action_valid,
    output logic                  explored,
    output logic                  busy
);

    sel_state_t            state;
    logic [STATE_W-1:0]    st_q;
    logic [7:0]            rnd_q;
    logic [1:0]            rpick_q;
    logic signed [Q_W-1:0] best_q;
    logic [1:0]            best_idx_q;
    logic                  have_best_q;
    logic [15:0]           lfsr_val;
    logic                  lfsr_unused;

    logic [1:0]            cap_idx;
    logic                  cap_ok;
    logic                  take;
    logic [1:0]            fin_idx;
    logic [1:0]            explore_pick;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_val)
    );

    assign lfsr_unused = ^lfsr_val[15:10];

    // Running argmax: the value arriving this cycle belongs to the action read one cycle earlier.
    always_comb begin
        case (state)
            S_READ1: cap_idx = 2'd0;
            S_READ2: cap_idx = 2'd1;
            S_READ3: cap_idx = 2'd2;
            default: cap_idx = 2'd3;
        endcase
`ifdef ACTION_MASK_EN
        cap_ok = act_legal(st_q, cap_idx);
`else
        cap_ok = 1'b1;
`endif
        take    = cap_ok && (!have_best_q || (q_rdata > best_q));
        fin_idx = take ? cap_idx : best_idx_q;
    end

    // Random pick, stepped forward past off-grid actions when masking is on.
    always_comb begin
        explore_pick = rpick_q;
`ifdef ACTION_MASK_EN
        for (int unsigned i = 0; i < 3; i++) begin
            if (!act_legal(st_q, explore_pick)) begin
                explore_pick = explore_pick + 2'd1;
            end
        end
`endif
    end

    // Decision FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            st_q         <= '0;
            rnd_q        <= '0;
            rpick_q      <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            have_best_q  <= 1'b0;
            q_rd_en      <= 1'b0;
            q_addr       <= '0;
            action       <= '0;
            action_valid <= 1'b0;
            explored     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            action_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        st_q        <= current_state;
                        rnd_q       <= lfsr_val[7:0];
                        rpick_q     <= lfsr_val[9:8];
                        have_best_q <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (rnd_q < epsilon) begin
                        state <= S_EXPLORE;
                    end else begin
                        q_rd_en <= 1'b1;
                        q_addr  <= {st_q, 2'd0};
                        state   <= S_READ0;
                    end
                end
                S_EXPLORE: begin
                    action       <= {{(ACT_W-2){1'b0}}, explore_pick};
                    explored     <= 1'b1;
                    action_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_READ0: begin
                    q_addr <= {st_q, 2'd1};
                    state  <= S_READ1;
                end
                S_READ1, S_READ2, S_READ3: begin
                    if (take) begin
                        best_q      <= q_rdata;
                        best_idx_q  <= cap_idx;
                        have_best_q <= 1'b1;
                    end
                    if (state == S_READ1) begin
                        q_addr <= {st_q, 2'd2};
                        state  <= S_READ2;
                    end else if (state == S_READ2) begin
                        q_addr <= {st_q, 2'd3};
                        state  <= S_READ3;
                    end else begin
                        q_rd_en <= 1'b0;
                        state   <= S_LAST;
                    end
                end
                S_LAST: begin
                    action       <= {{(ACT_W-2){1'b0}}, fin_idx};
                    explored     <= 1'b0;
                    action_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_action_selector.sv
// Self-checking bench for action_selector: a transaction-level model of the
// epsilon-greedy policy predicts every output each cycle; directed cases pin
// the model with hand-computed values.
module tb_action_selector;

    localparam logic [15:0] SEED = 16'hACE1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [5:0]         current_state;
    logic [7:0]         epsilon;
    logic               q_rd_en;
    logic [7:0]         q_addr;
    logic signed [15:0] q_rdata = '0;
    logic [3:0]         action;
    logic               action_valid;
    logic               explored;
    logic               busy;

    always #5 clk = ~clk;

    action_selector #(.LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .current_state (current_state),
        .epsilon       (epsilon),
        .q_rd_en       (q_rd_en),
        .q_addr        (q_addr),
        .q_rdata       (q_rdata),
        .action        (action),
        .action_valid  (action_valid),
        .explored      (explored),
        .busy          (busy)
    );

    // Q-table memory: one-cycle read latency.
    logic signed [15:0] mem [256];
    always @(posedge clk) if (q_rd_en) q_rdata <= mem[q_addr];

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;
    logic [7:0] addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [5:0] s, input int a);
`ifdef ACTION_MASK_EN
        int row = int'(s) / 8;
        int col = int'(s) % 8;
        case (a)
            0: return row != 0;
            1: return row != 7;
            2: return col != 0;
            default: return col != 7;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    function automatic int argmax_q(input logic [5:0] s);
        int best = -1;
        int bv = 0;
        for (int a = 0; a < 4; a++) begin
            int v = mem[int'(s) * 4 + a];
            if (legal(s, a) && (best < 0 || v > bv)) begin
                best = a;
                bv = v;
            end
        end
        return best;
    endfunction

    function automatic int explore_pick(input logic [5:0] s, input int rp);
        int a = rp;
        for (int i = 0; i < 4; i++) if (!legal(s, a)) a = (a + 1) % 4;
        return a;
    endfunction

    bit         m_op;
    int         m_t, m_lat;
    bit         m_expl_mode;
    logic [5:0] m_st;
    logic [7:0] m_rnd;
    int         m_rpick;
    logic [3:0] m_action;
    bit         m_explored;
    logic [15:0] m_lfsr;

    // Model advances on each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_op = 0; m_t = 0; m_lat = 0; m_expl_mode = 0;
            m_action = 0; m_explored = 0; m_lfsr = SEED;
        end else begin
            if (m_op) begin
                m_t++;
                if (m_t == 1) begin
                    m_expl_mode = (m_rnd < epsilon);
                    m_lat = m_expl_mode ? 2 : 6;
                end
                if (m_t == m_lat) begin
                    m_action = m_expl_mode ? 4'(explore_pick(m_st, m_rpick)) : 4'(argmax_q(m_st));
                    m_explored = m_expl_mode;
                end
                if (m_t == m_lat + 1) m_op = 0;
            end else if (start) begin
                m_op = 1; m_t = 0; m_lat = 99;
                m_st = current_state;
                m_rnd = m_lfsr[7:0];
                m_rpick = int'(m_lfsr[9:8]);
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && checking) begin
            bit e_rd;
            e_rd = m_op && !m_expl_mode && m_t >= 1 && m_t <= 4;
            chk("busy", busy, m_op);
            chk("action_valid", action_valid, m_op && m_t == m_lat);
            chk("action", action, m_action);
            chk("explored", explored, m_explored);
            chk("q_rd_en", q_rd_en, e_rd);
            if (e_rd) chk("q_addr", q_addr, {m_st, 2'(m_t - 1)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n = 0;
        while (m_op && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n >= 50, 0);
    endtask

    task automatic run_txn(input logic [5:0] s, input logic [7:0] eps, output int lat);
        wait_idle();
        current_state = s;
        epsilon = eps;
        start = 1;
        addr_log.delete();
        @(negedge clk);
        start = 0;
        current_state = 6'($urandom);
        lat = 0;
        while (!action_valid && lat < 20) begin
            if (q_rd_en) addr_log.push_back(q_addr);
            @(negedge clk);
            lat++;
        end
        chk("valid_timeout", lat >= 20, 0);
    endtask

    task automatic set_q(input logic [5:0] s, input int q0, input int q1, input int q2, input int q3);
        mem[int'(s) * 4 + 0] = 16'(q0);
        mem[int'(s) * 4 + 1] = 16'(q1);
        mem[int'(s) * 4 + 2] = 16'(q2);
        mem[int'(s) * 4 + 3] = 16'(q3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_action"}, action, 0);
        chk({tag, "_valid"}, action_valid, 0);
        chk({tag, "_explored"}, explored, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, q_rd_en, 0);
        chk({tag, "_addr"}, q_addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int hits;
        rst_n = 0; start = 0; epsilon = 0; current_state = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;
        checking = 1;
        @(negedge clk);

        // Exploit, state (1,0): Q={10,-5,40,7} -> left
        set_q(6'b001000, 10, -5, 40, 7);
        run_txn(6'b001000, 8'd0, lat);
        chk("exploit_latency", lat, 6);
        chk("exploit_action", action, 4'b0010);
        chk("exploit_explored", explored, 0);
        chk("exploit_nreads", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("exploit_addr_seq", addr_log[i], 8'h20 + i);

        // Tie resolves to lowest index; all-minimum resolves to up
        set_q(6'b010011, 3, 9, 9, -1);
        run_txn(6'b010011, 8'd0, lat);
        chk("tie_action", action, 4'b0001);
        set_q(6'b101010, -32768, -32768, -32768, -32768);
        run_txn(6'b101010, 8'd0, lat);
        chk("allmin_action", action, 4'b0000);

        // Forced exploration
        for (int k = 0; k < 3; k++) begin
            run_txn(6'($urandom_range(9, 54)), 8'd255, lat);
            if (m_rnd != 8'hFF) begin
                chk("explore_latency", lat, 2);
                chk("explore_flag", explored, 1);
                chk("explore_action", action, 4'(explore_pick(m_st, m_rpick)));
                chk("explore_no_reads", addr_log.size(), 0);
            end
        end

        // Start held high for 10 cycles: one decision per idle entry
        wait_idle();
        epsilon = 8'd128;
        current_state = 6'd27;
        start = 1;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (action_valid) hits++;
        end
        start = 0;
        wait_idle();
        chk("spam_decisions", hits >= 1, 1);

        // Reset in the middle of READ2, then a clean decision
        set_q(6'd20, 1, 2, 3, 4);
        wait_idle();
        current_state = 6'd20; epsilon = 8'd0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1;
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (action_valid) hits++;
        end
        chk("midreset_no_valid", hits, 0);
        run_txn(6'd20, 8'd0, lat);
        chk("post_reset_latency", lat, 6);
        chk("post_reset_action", action, 4'b0011);

`ifdef ACTION_MASK_EN
        set_q(6'b001000, 0, 0, 100, 0);
        run_txn(6'b001000, 8'd0, lat);
        chk("mask_exploit_action", action, 4'b0000);
        hits = 0;
        wait_idle();
        while (!(m_lfsr[9:8] == 2'd2 && m_lfsr[7:0] != 8'hFF) && hits < 2000) begin
            @(negedge clk);
            hits++;
        end
        chk("mask_seek_timeout", hits >= 2000, 0);
        run_txn(6'b001000, 8'd255, lat);
        chk("mask_explore_action", action, 4'b0011);
        chk("mask_explore_flag", explored, 1);
`endif

        // Randomized decisions
        for (int n = 0; n < 60; n++) begin
            logic [5:0] s;
            logic [7:0] e;
            s = 6'($urandom);
            for (int a = 0; a < 4; a++) mem[int'(s) * 4 + a] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mem[int'(s) * 4 + 1] = mem[int'(s) * 4 + 3];
            case ($urandom_range(0, 3))
                0: e = 8'd0;
                1: e = 8'd255;
                default: e = 8'($urandom);
            endcase
            run_txn(s, e, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/action_selector.md
Name: action_selector

Overview:
- Epsilon-greedy policy block: the producer of the `at` action code that penentu_state-style next-state logic consumes.
- On `start` it snapshots `current_state` and decides explore vs. exploit from a free-running LFSR.
- Exploit path: reads the four Q-values for that state from the Q-table memory and registers the argmax action, with a valid pulse.
- Sits between the Q-table RAM and the state-transition block in the learning loop.

Parameters:
- STATE_W, 6, state code width; 8x8 grid, row = state[5:3], col = state[2:0].
- ACT_W, 4, action code width. Legal codes are 4'b0000 up (row-1), 4'b0001 down (row+1), 4'b0010 left (col-1), 4'b0011 right (col+1).
- Q_W, 16, signed Q-value width.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a decision; sampled only in IDLE.
- current_state  in  STATE_W  state to decide for; latched when start is accepted.
- epsilon  in  8  exploration threshold; explore when rnd < epsilon.
- q_rd_en  out  1  Q-table read strobe.
- q_addr  out  STATE_W+2  {latched_state, action[1:0]}.
- q_rdata  in  Q_W  signed Q-value; valid exactly 1 cycle after q_rd_en.
- action  out  ACT_W  selected action; held until the next decision completes.
- action_valid  out  1  one-cycle pulse when `action` updates.
- explored  out  1  1 = action was random; valid with action_valid, held afterwards.
- busy  out  1  high from start acceptance until the action_valid cycle inclusive.

Behaviour:
- Reset values: action=0, action_valid=0, explored=0, busy=0, q_rd_en=0, q_addr=0, FSM=IDLE, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle, including IDLE.
- rnd = lfsr[7:0]; rpick = lfsr[9:8]. Both are snapshotted at the start edge (E0).
- States: IDLE -> DECIDE -> (EXPLORE | READ0..READ3 -> LAST) -> DONE -> IDLE.
- E0 (start high in IDLE):
  - latch state, rnd, rpick;
  - busy=1;
  - go to DECIDE.
- E1 (DECIDE):
  - if rnd < epsilon: go to EXPLORE;
  - else: go to READ0, with q_rd_en=1, q_addr={st,2'd0}.
- Explore path:
  - EXPLORE at E2 registers action=rpick (zero-extended) and explored=1.
  - DONE follows; action_valid is high in the cycle after E2. Latency 2 cycles, start to valid.
- Exploit path:
  - READk drives q_addr={st,k} with q_rd_en=1; READ3 is the last issue, LAST issues nothing.
  - q_rdata for action k-1 is captured in READk; action 3 is captured in LAST.
  - Running max comparison is signed. Replacement happens only on strictly greater, so ties resolve to the lowest action index.
  - Action registered at LAST exit (E6) with explored=0; action_valid high in the cycle after E6. Latency 6 cycles.
- DONE: action_valid=1, busy=1 for one cycle, then IDLE with busy=0. A start on this cycle is ignored.
- Boundaries:
  - start while busy: ignored, no queueing.
  - epsilon=0: never explore.
  - epsilon=255: explore unless rnd==255.
  - current_state changes after E0: no effect.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. The partial decision is discarded; no action_valid is produced.

Optional Feature:
- Macro ACTION_MASK_EN. When defined, actions that leave the grid are masked:
  - up when row==0;
  - down when row==7;
  - left when col==0;
  - right when col==7.
- Exploit: masked actions are excluded from the argmax. Q reads are still issued for all four actions, so latency is unchanged.
- Explore: a masked rpick advances cyclically (+1 mod 4) to the next unmasked action. Every cell has at least 2 legal actions, so this always terminates.
- Without the macro: no masking; the grid edge is the consumer's concern.

Decomposition:
- Shared package rl_pkg holds:
  - STATE_W, ACT_W, Q_W;
  - action code constants ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT;
  - state enum for this FSM;
  - row/col extraction functions (reused by the state block).
- One natural sub-module: lfsr16 (enable-free, seeded, 16-bit output). The argmax stays inline.

Test Plan:
- Reset mid-READ2 (rst_n low 1 cycle) -> all outputs 0, no action_valid; a fresh start then completes normally.
- epsilon=0, state 6'b001000, Q={10,-5,40,7} -> action_valid 6 cycles after start, action=4'b0010, explored=0; q_addr sequence 8'h20,8'h21,8'h22,8'h23.
- epsilon=0, Q={3,9,9,-1} -> action=4'b0001 (tie to lowest); Q all equal -32768 -> action=4'b0000.
- epsilon=255 with rnd≠255 -> action_valid 2 cycles after start, explored=1, action == the model LFSR's rpick at E0, no q_rd_en.
- start pulsed every cycle for 10 cycles -> exactly one decision per IDLE entry; busy never drops while the FSM is not idle.
- ACTION_MASK_EN defined:
  - state 6'b001000, epsilon=0, Q={0,0,100,0} -> action=4'b0000 (left masked);
  - forced explore with rpick=2 -> action=4'b0011.
